alu_reservation_station: RTL and testbench

//  Issuing side of the ALU op/operand/des interface: an 8-entry reservation station between dispatch and ALU.

---
 rtl/alu_reservation_station.sv | 155 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: 8-entry ALU reservation station. Buffers dispatched
// ALU ops until both operands are ready (snooping the CDB), issues the lowest
// ready entry each cycle tagged with its index, and re-associates the ALU result
// with the owning ROB tag when the ALU reports completion.
module alu_reservation_station #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [31:0]      in_v1,
  input  logic [31:0]      in_v2,
  input  logic             in_q1_valid,
  input  logic [ROB_W-1:0] in_q1,
  input  logic             in_q2_valid,
  input  logic [ROB_W-1:0] in_q2,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob,
  input  logic [31:0]      cdb_value,
  output logic             alu_valid,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [IDX_W-1:0] alu_des,
  input  logic             alu_done,
  input  logic [IDX_W-1:0] alu_done_des,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_rob,
  output logic [31:0]      out_value
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_ISSUED} state_t;

  typedef struct packed {
    state_t           st;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             r1;
    logic             r2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
  } entry_t;

  entry_t           ent [ENTRIES];
  entry_t           new_ent;
  logic             any_free;
  logic [IDX_W-1:0] free_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             do_disp;
  logic             done_hit;
  logic             byp1;
  logic             byp2;

  // Priority pick of lowest FREE slot and lowest issue-ready WAIT slot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_free  = 1'b0;
    free_idx  = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].st == S_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent[i].st == S_WAIT && ent[i].r1 && ent[i].r2) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign in_ready = any_free & ~flush;
  assign do_disp  = in_valid & in_ready;
  assign done_hit = alu_done && (ent[alu_done_des].st == S_ISSUED);

  // Build the entry written on dispatch, bypassing a same-cycle CDB match.
  always_comb begin
    byp1       = in_q1_valid && cdb_valid && (cdb_rob == in_q1);
    byp2       = in_q2_valid && cdb_valid && (cdb_rob == in_q2);
    new_ent.st  = S_WAIT;
    new_ent.op  = in_op;
    new_ent.rob = in_rob;
    new_ent.q1  = in_q1;
    new_ent.q2  = in_q2;
    new_ent.r1  = !in_q1_valid || byp1;
    new_ent.r2  = !in_q2_valid || byp2;
    new_ent.v1  = byp1 ? cdb_value : in_v1;
    new_ent.v2  = byp2 ? cdb_value : in_v2;
  end

  // Entry state machine, wakeup, issue and completion registers.
  // NOTE: sequential state uses non-blocking assignments so all updates see cycle-start values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the state field is reset; payload is don't-care while FREE.
      for (int i = 0; i < ENTRIES; i++) ent[i].st <= S_FREE;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_v1    <= '0;
      alu_v2    <= '0;
      alu_des   <= '0;
      out_valid <= 1'b0;
      out_rob   <= '0;
      out_value <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].st <= S_FREE;
      alu_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (ent[i].st == S_WAIT && cdb_valid) begin
          if (!ent[i].r1 && cdb_rob == ent[i].q1) begin
            ent[i].v1 <= cdb_value;
            ent[i].r1 <= 1'b1;
          end
          if (!ent[i].r2 && cdb_rob == ent[i].q2) begin
            ent[i].v2 <= cdb_value;
            ent[i].r2 <= 1'b1;
          end
        end
      end

      alu_valid <= sel_valid;
      if (sel_valid) begin
        ent[sel_idx].st <= S_ISSUED;
        alu_op          <= ent[sel_idx].op;
        alu_v1          <= ent[sel_idx].v1;
        alu_v2          <= ent[sel_idx].v2;
        alu_des         <= sel_idx;
      end

      out_valid <= done_hit;
      if (done_hit) begin
        ent[alu_done_des].st <= S_FREE;
        out_rob              <= ent[alu_done_des].rob;
        out_value            <= alu_result;
      end

      if (do_disp) ent[free_idx] <= new_ent;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scenarios plus randomized traffic checked
// by a scoreboard fed from a slot-level behavioural model of the station.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_op, in_rob, in_q1, in_q2, cdb_rob;
  logic [31:0] in_v1, in_v2, cdb_value, alu_result;
  logic        in_q1_valid, in_q2_valid, cdb_valid;
  logic        alu_valid, alu_done, out_valid;
  logic [3:0]  alu_op, out_rob;
  logic [31:0] alu_v1, alu_v2, out_value;
  logic [2:0]  alu_des, alu_done_des;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob(in_rob),
    .in_v1(in_v1), .in_v2(in_v2),
    .in_q1_valid(in_q1_valid), .in_q1(in_q1), .in_q2_valid(in_q2_valid), .in_q2(in_q2),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_des(alu_des),
    .alu_done(alu_done), .alu_done_des(alu_done_des), .alu_result(alu_result),
    .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: per-slot occupancy (0 free, 1 waiting, 2 at the ALU).
  int          m_st [8];
  logic [3:0]  m_op [8], m_rob [8], m_q1 [8], m_q2 [8];
  logic [31:0] m_v1 [8], m_v2 [8];
  bit          m_p1 [8], m_p2 [8];

  logic [70:0] alu_q [$];
  logic [35:0] out_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_has_free();
    for (int i = 0; i < 8; i++) if (m_st[i] == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int sel, fi, d;
    if (rst || flush) begin
      for (int i = 0; i < 8; i++) m_st[i] = 0;
      return;
    end
    sel = -1;
    fi  = -1;
    for (int i = 7; i >= 0; i--) begin
      if (m_st[i] == 1 && !m_p1[i] && !m_p2[i]) sel = i;
      if (m_st[i] == 0) fi = i;
    end
    d = int'(alu_done_des);
    if (alu_done && m_st[d] == 2) begin
      out_q.push_back({m_rob[d], alu_result});
      m_st[d] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_st[i] == 1 && cdb_valid) begin
        if (m_p1[i] && m_q1[i] == cdb_rob) begin m_v1[i] = cdb_value; m_p1[i] = 0; end
        if (m_p2[i] && m_q2[i] == cdb_rob) begin m_v2[i] = cdb_value; m_p2[i] = 0; end
      end
    end
    if (sel >= 0) begin
      alu_q.push_back({m_op[sel], m_v1[sel], m_v2[sel], 3'(sel)});
      m_st[sel] = 2;
    end
    if (in_valid && fi >= 0) begin
      m_st[fi]  = 1;
      m_op[fi]  = in_op;
      m_rob[fi] = in_rob;
      m_q1[fi]  = in_q1;
      m_q2[fi]  = in_q2;
      m_p1[fi]  = in_q1_valid && !(cdb_valid && cdb_rob == in_q1);
      m_p2[fi]  = in_q2_valid && !(cdb_valid && cdb_rob == in_q2);
      m_v1[fi]  = (in_q1_valid && !m_p1[fi]) ? cdb_value : in_v1;
      m_v2[fi]  = (in_q2_valid && !m_p2[fi]) ? cdb_value : in_v2;
    end
  endtask

  // One clock: inputs are set just after a falling edge; ends at the next falling edge.
  task automatic tick();
    #1;
    if (!rst) check("in_ready", in_ready, m_has_free() && !flush);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_op = 0; in_rob = 0; in_v1 = 0; in_v2 = 0;
    in_q1_valid = 0; in_q1 = 0; in_q2_valid = 0; in_q2 = 0;
    cdb_valid = 0; cdb_rob = 0; cdb_value = 0;
    alu_done = 0; alu_done_des = 0; alu_result = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob, input logic [31:0] v1,
                      input logic [31:0] v2, input logic q1v, input logic [3:0] q1,
                      input logic q2v, input logic [3:0] q2);
    in_valid = 1; in_op = op; in_rob = rob; in_v1 = v1; in_v2 = v2;
    in_q1_valid = q1v; in_q1 = q1; in_q2_valid = q2v; in_q2 = q2;
  endtask

  task automatic complete(input logic [2:0] des, input logic [31:0] res);
    alu_done = 1; alu_done_des = des; alu_result = res;
  endtask

  // Scoreboard monitor: every expected transaction is due at the next falling edge.
  always @(negedge clk) begin
    logic [70:0] ea;
    logic [35:0] eo;
    if (alu_q.size() != 0) begin
      ea = alu_q.pop_front();
      if (alu_valid !== 1'b1) check("alu_missing", alu_valid, 1'b1);
      else check("alu_issue", {alu_op, alu_v1, alu_v2, alu_des}, ea);
    end else if (alu_valid === 1'b1) begin
      check("alu_unexpected", alu_valid, 1'b0);
    end
    if (out_q.size() != 0) begin
      eo = out_q.pop_front();
      if (out_valid !== 1'b1) check("out_missing", out_valid, 1'b1);
      else check("out_bcast", {out_rob, out_value}, eo);
    end else if (out_valid === 1'b1) begin
      check("out_unexpected", out_valid, 1'b0);
    end
  end

  initial begin
    int iss [$];
    idle();
    rst = 1;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    check("rst_outs", {alu_valid, out_valid, alu_op, alu_v1, alu_v2, alu_des, out_rob, out_value}, '0);
    check("rst_in_ready", in_ready, 1'b1);

    // Both operands ready: issue, then completion broadcast.
    disp(0, 3, 5, 7, 0, 0, 0, 0); tick(); idle(); tick();
    check("t1_issue", {alu_valid, alu_op, alu_v1, alu_v2, alu_des}, {1'b1, 4'd0, 32'd5, 32'd7, 3'd0});
    complete(0, 12); tick(); idle();
    check("t1_bcast", {out_valid, out_rob, out_value}, {1'b1, 4'd3, 32'd12});

    // CDB wakeup two cycles after dispatch.
    disp(1, 4, 0, 3, 1, 6, 0, 0); tick(); idle(); tick();
    cdb_valid = 1; cdb_rob = 6; cdb_value = 32'h10; tick(); idle(); tick();
    check("t2_wake", {alu_valid, alu_v1, alu_v2, alu_des}, {1'b1, 32'h10, 32'd3, 3'd0});
    complete(0, 32'h13); tick(); idle();

    // Same-cycle dispatch + CDB bypass.
    disp(2, 5, 32'h21, 0, 0, 0, 1, 9);
    cdb_valid = 1; cdb_rob = 9; cdb_value = 32'h55; tick(); idle(); tick();
    check("t2_bypass", {alu_valid, alu_v1, alu_v2}, {1'b1, 32'h21, 32'h55});
    complete(0, 1); tick(); idle();

    // Fill all entries; entries 2 and 5 share a producer tag.
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 4'(i), 0, 100 + i, 1, (i == 5) ? 4'd2 : 4'(i), 0, 0);
      tick();
    end
    idle();
    #1 check("t3_full", in_ready, 1'b0);
    disp(9, 9, 1, 1, 0, 0, 0, 0); tick(); idle();
    cdb_valid = 1; cdb_rob = 2; cdb_value = 32'h77; tick(); idle(); tick();
    check("t3_first", {alu_valid, alu_des, alu_v1}, {1'b1, 3'd2, 32'h77});
    tick();
    check("t3_second", {alu_valid, alu_des, alu_v1}, {1'b1, 3'd5, 32'h77});

    // Flush with completion in the same cycle; later stale completion dropped.
    flush = 1; complete(2, 32'hdead); disp(1, 1, 1, 1, 0, 0, 0, 0); tick(); idle();
    check("t4_flush_outs", {alu_valid, out_valid}, 2'b00);
    #1 check("t4_in_ready", in_ready, 1'b1);
    complete(2, 32'hbeef); tick(); idle();
    check("t4_stale_done", out_valid, 1'b0);

    // Dispatch, issue and completion in one cycle; freed slot reused next cycle.
    disp(3, 10, 1, 2, 0, 0, 0, 0); tick();
    disp(4, 11, 3, 4, 0, 0, 0, 0); tick();
    disp(5, 12, 5, 6, 0, 0, 0, 0); complete(0, 32'haa); tick(); idle();
    check("t5_same_cycle", {alu_valid, alu_des, out_valid, out_rob, out_value},
          {1'b1, 3'd1, 1'b1, 4'd10, 32'haa});
    disp(6, 13, 7, 8, 0, 0, 0, 0); tick(); idle();
    check("t5_c_issue", {alu_valid, alu_des}, {1'b1, 3'd2});
    tick();
    check("t5_realloc", {alu_valid, alu_des, alu_v1}, {1'b1, 3'd0, 32'd7});
    complete(1, 1); tick(); complete(2, 2); tick(); complete(0, 3); tick(); idle();

    // Reset in the middle of traffic.
    disp(7, 14, 9, 9, 0, 0, 0, 0); tick();
    disp(8, 15, 1, 1, 1, 3, 0, 0); tick(); idle();
    rst = 1; tick(); rst = 0;
    check("t6_rst_outs", {alu_valid, out_valid, alu_op, alu_v1, alu_v2, alu_des, out_rob, out_value}, '0);
    #1 check("t6_in_ready", in_ready, 1'b1);
    complete(0, 5); tick(); idle();
    check("t6_stale_done", out_valid, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        disp(4'($urandom_range(0, 13)), 4'($urandom), $urandom, $urandom,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) < 2) begin
        cdb_valid = 1; cdb_rob = 4'($urandom_range(0, 3)); cdb_value = $urandom;
      end
      iss.delete();
      for (int i = 0; i < 8; i++) if (m_st[i] == 2) iss.push_back(i);
      if (iss.size() != 0 && $urandom_range(0, 3) != 0)
        complete(3'(iss[$urandom_range(0, iss.size() - 1)]), $urandom);
      else if ($urandom_range(0, 3) == 0)
        complete(3'($urandom_range(0, 7)), $urandom);
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;

    // Drain: complete everything left at the ALU.
    for (int c = 0; c < 40; c++) begin
      idle();
      cdb_valid = 1; cdb_rob = 4'(c % 4); cdb_value = 32'(c);
      for (int i = 7; i >= 0; i--) if (m_st[i] == 2) complete(3'(i), 32'(c) + 32'h100);
      tick();
    end
    idle(); tick(); tick();
    check("alu_q_drained", alu_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
